// File: rtl/op_issue_ctrl_pkg.sv
// Shared widths, FSM encoding and instruction record for the op issue stage.
// Imported by the issue controller and its buffer.
package op_issue_ctrl_pkg;

  localparam int OP_W  = 4;
  localparam int ARG_W = 4;
  localparam int TMR_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } instr_t;

endpackage

// File: rtl/op_issue_ctrl_sync_fifo.sv
// Synchronous FIFO with registered pointers/count and head-of-queue read data.
// Push is ignored when full and pop when empty; no pass-through from push to pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/op_issue_ctrl.sv
// Issue stage ahead of the 4-to-16 decoder: buffers op/arg pairs and holds one op
// in EXEC until exec_done or timeout; back-to-back issue on exec_done.
module op_issue_ctrl
  import op_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  input  logic [OP_W-1:0]              i_in_op,
  input  logic [ARG_W-1:0]             i_in_arg,
  output logic                         o_in_ready,
  output logic [OP_W-1:0]              o_dec_in,
  output logic                         o_dec_en,
  output logic [ARG_W-1:0]             o_arg_out,
  input  logic                         i_exec_done,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_timeout_err,
  input  logic                         i_clr_err
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [OP_W-1:0]   r_op;
  logic [ARG_W-1:0]  r_arg;
  logic              r_err;
  logic              w_err_set;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  instr_t            w_push_dat;
  instr_t            w_head;

  assign w_push_dat = {i_in_op, i_in_arg};

  sync_fifo #(
    .WIDTH ($bits(instr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_in_valid),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (o_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_EXEC;
          w_timer_nxt = '0;
        end
      end
      ST_EXEC: begin
        // Completion outranks a timeout landing in the same cycle.
        if (i_exec_done) begin
          w_timer_nxt = '0;
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end else if (r_timer == TMO_LAST) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_op    <= '0;
      r_arg   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_pop) begin
        r_op  <= w_head.op;
        r_arg <= w_head.arg;
      end
      if (w_err_set)      r_err <= 1'b1;
      else if (i_clr_err) r_err <= 1'b0;
    end
  end

  assign o_dec_en      = (r_state == ST_EXEC);
  assign o_dec_in      = r_op;
  assign o_arg_out     = r_arg;
  assign o_timeout_err = r_err;
  assign o_in_ready    = !w_full;
  assign o_busy        = (r_state == ST_EXEC) || !w_empty;

endmodule

// File: tb/tb_op_issue_ctrl.sv
// Bench for op_issue_ctrl: vector table for the single-op flow, hand sequences for
// fill/back-to-back, timeout, collision, push/pop overlap and reset; scoreboard on issue order.
module tb_op_issue_ctrl;
  import op_issue_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_op = '0;
  logic [3:0]    in_arg = '0;
  logic          exec_done = 1'b0;
  logic          clr_err = 1'b0;
  logic          in_ready;
  logic [3:0]    dec_in;
  logic          dec_en;
  logic [3:0]    arg_out;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          timeout_err;

  always #5 clk = ~clk;

  op_issue_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .i_in_op       (in_op),
    .i_in_arg      (in_arg),
    .o_in_ready    (in_ready),
    .o_dec_in      (dec_in),
    .o_dec_en      (dec_en),
    .o_arg_out     (arg_out),
    .i_exec_done   (exec_done),
    .o_busy        (busy),
    .o_fifo_count  (fifo_count),
    .o_timeout_err (timeout_err),
    .i_clr_err     (clr_err)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] arg);
    in_valid = 1'b1;
    in_op    = op;
    in_arg   = arg;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_en();
    for (int k = 0; k < 20 && !dec_en; k++) tick();
    chk("wait_en", dec_en, 1);
  endtask

  // Scoreboard: accepted pairs queue up; each issue edge must present the oldest one.
  initial begin
    logic       p_rst, p_acc, p_en, p_done;
    logic [7:0] p_dat;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      p_rst  = rst_n;
      p_acc  = in_valid && (exp_q.size() < DEPTH);
      p_dat  = {in_op, in_arg};
      p_en   = dec_en;
      p_done = exec_done;
      @(posedge clk);
      #1;
      if (p_rst && rst_n) begin
        if (dec_en && (!p_en || p_done)) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_issue: got op/arg %0h%0h, expected no issue", dec_in, arg_out);
          end else begin
            e = exp_q.pop_front();
            chk("sb_issue", {dec_in, arg_out}, e);
          end
        end
        if (p_acc) exp_q.push_back(p_dat);
        chk("sb_count", fifo_count, exp_q.size());
        chk("sb_ready", in_ready, (exp_q.size() < DEPTH) ? 1 : 0);
      end
    end
  end

  typedef struct {
    logic          vld;
    logic [3:0]    op;
    logic [3:0]    arg;
    logic          done;
    logic          exp_en;
    logic [3:0]    exp_din;
    logic [3:0]    exp_arg;
    logic          exp_busy;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   n;
    vt[0] = '{1'b1, 4'h3, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 3'd1};
    vt[1] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b1, 3'd0};
    vt[2] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b1, 3'd0};
    vt[3] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b1, 3'd0};
    vt[4] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0};
    vt[5] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'd0};

    // Reset state
    #12;
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_in", dec_in, 0);
    chk("rst_arg_out", arg_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;

    // Single op through the vector table
    for (int i = 0; i < 6; i++) begin
      in_valid  = vt[i].vld;
      in_op     = vt[i].op;
      in_arg    = vt[i].arg;
      exec_done = vt[i].done;
      tick();
      chk($sformatf("vec%0d_en", i), dec_en, vt[i].exp_en);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      chk($sformatf("vec%0d_cnt", i), fifo_count, vt[i].exp_cnt);
      if (vt[i].exp_en) begin
        chk($sformatf("vec%0d_din", i), dec_in, vt[i].exp_din);
        chk($sformatf("vec%0d_arg", i), arg_out, vt[i].exp_arg);
      end
    end
    in_valid  = 1'b0;
    exec_done = 1'b0;

    // Fill: op0 goes to EXEC, ops 1..4 fill the buffer
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_op  = 4'(i);
      in_arg = 4'(i + 8);
      tick();
    end
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", in_ready, 0);
    chk("fill_din0", dec_in, 0);
    in_op  = 4'h5;
    in_arg = 4'hD;
    tick();
    chk("full_hold_count", fifo_count, 4);
    exec_done = 1'b1;
    tick();
    chk("no_passthru_count", fifo_count, 3);
    chk("b2b_din1", dec_in, 1);
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("b2b_en%0d", k), dec_en, 1);
      chk($sformatf("b2b_din%0d", k), dec_in, k);
    end
    tick();
    chk("b2b_drain_en", dec_en, 0);
    chk("b2b_drain_busy", busy, 0);
    exec_done = 1'b0;

    // Timeout after exactly TMO EXEC cycles
    push(4'hF, 4'h1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dec_en) n++;
      else if (n > 0) break;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_err_set", timeout_err, 1);

    // Set beats a simultaneous clear
    push(4'hE, 4'h2);
    wait_en();
    repeat (TMO - 1) tick();
    chk("tmo2_en_last", dec_en, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo2_en", dec_en, 0);
    chk("set_beats_clr", timeout_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("lone_clr", timeout_err, 0);

    // Done on the final EXEC cycle wins over timeout
    push(4'h7, 4'h3);
    wait_en();
    repeat (TMO - 1) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("coll_en", dec_en, 0);
    chk("coll_err", timeout_err, 0);
    chk("coll_busy", busy, 0);

    // Push and pop on the same edge
    in_valid = 1'b1;
    in_op = 4'h8; in_arg = 4'h1; tick();
    in_op = 4'h9; in_arg = 4'h2; tick();
    in_op = 4'hA; in_arg = 4'h3; tick();
    chk("pp_pre_count", fifo_count, 2);
    chk("pp_pre_din", dec_in, 8);
    in_op = 4'hB; in_arg = 4'h4;
    exec_done = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_count", fifo_count, 2);
    chk("pp_din", dec_in, 9);
    tick();
    chk("pp_dinA", dec_in, 4'hA);
    tick();
    chk("pp_dinB", dec_in, 4'hB);
    tick();
    chk("pp_idle", dec_en, 0);
    exec_done = 1'b0;

    // Asynchronous reset mid-EXEC with ops queued
    in_valid = 1'b1;
    in_op = 4'hC; in_arg = 4'h6; tick();
    in_op = 4'hD; in_arg = 4'h7; tick();
    in_op = 4'hE; in_arg = 4'h8; tick();
    in_valid = 1'b0;
    chk("mid_count", fifo_count, 2);
    chk("mid_en", dec_en, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_dec_en", dec_en, 0);
    chk("arst_dec_in", dec_in, 0);
    chk("arst_arg_out", arg_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_en", dec_en, 0);
      chk("post_rst_busy", busy, 0);
    end
    push(4'h2, 4'h9);
    tick();
    chk("post_rst_issue_en", dec_en, 1);
    chk("post_rst_issue_din", dec_in, 2);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
